// File: rtl/reg_serializer.sv
// -----------------------------------------------------------------------------
// reg_serializer
//
// Parallel-to-serial transmitter. A word captured on `load` is sent as one
// frame: start bit (0), DATA_W data bits LSB first, then stop bit (1). Each bit
// is held on the line for CLK_DIV clock cycles. All outputs are registered.
//
// Parameters
//   CLK_DIV  clk cycles per serial bit period (2 .. 2^26-1)
//   DATA_W   width of the parallel data word
//
// Ports
//   clk       system clock, rising edge
//   clr       synchronous active-high reset; wins over load
//   load      transmit request, accepted only while ready
//   d         parallel word, captured when load is accepted
//   ready     high while idle and able to accept load
//   sout      serial line, idles high
//   bit_tick  one-cycle strobe on the last cycle of every bit period
//   done      one-cycle pulse on the first idle cycle after a frame
// -----------------------------------------------------------------------------
module reg_serializer #(
    parameter int CLK_DIV = 50000000,
    parameter int DATA_W  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic              ready,
    output logic              sout,
    output logic              bit_tick,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [25:0]      DIV_LAST = 26'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state, state_next;
    logic [25:0]       div, div_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic              wrap;
    logic              sout_next;
    logic              bit_tick_next;
    logic              done_next;

    always_comb begin
        state_next = state;
        div_next   = div;
        idx_next   = idx;
        shreg_next = shreg;
        wrap       = (div == DIV_LAST);

        case (state)
            IDLE: begin
                div_next = '0;
                idx_next = '0;
                if (load) begin
                    shreg_next = d;
                    state_next = START;
                end
            end
            START: begin
                div_next = wrap ? 26'd0 : div + 26'd1;
                if (wrap) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                div_next = wrap ? 26'd0 : div + 26'd1;
                if (wrap) begin
                    shreg_next = shreg >> 1;
                    idx_next   = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                div_next = wrap ? 26'd0 : div + 26'd1;
                if (wrap) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are derived from the next state so that, once registered,
        // they line up with the state they describe (no extra cycle of lag).
        case (state_next)
            START:   sout_next = 1'b0;
            DATA:    sout_next = shreg_next[0];
            default: sout_next = 1'b1;
        endcase
        bit_tick_next = (state_next != IDLE) && (div_next == DIV_LAST);
        done_next     = (state == STOP) && (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            div      <= '0;
            idx      <= '0;
            shreg    <= '0;
            sout     <= 1'b1;
            ready    <= 1'b1;
            bit_tick <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            div      <= div_next;
            idx      <= idx_next;
            shreg    <= shreg_next;
            sout     <= sout_next;
            ready    <= (state_next == IDLE);
            bit_tick <= bit_tick_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_reg_serializer.sv
// -----------------------------------------------------------------------------
// tb_reg_serializer
//
// Directed self-checking bench for reg_serializer with CLK_DIV=4, DATA_W=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_reg_serializer;

    logic       clk;
    logic       clr;
    logic       load;
    logic [3:0] d;
    logic       ready;
    logic       sout;
    logic       bit_tick;
    logic       done;

    int tests = 0;
    int fails = 0;

    reg_serializer #(
        .CLK_DIV(4),
        .DATA_W (4)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .load    (load),
        .d       (d),
        .ready   (ready),
        .sout    (sout),
        .bit_tick(bit_tick),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr  = 1'b1;
        load = 1'b0;
        d    = 4'b0000;
        tick();
        tick();
        clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b0 || bit_tick !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d got sout=%b ready=%b done=%b bit_tick=%b, required 1 1 0 0",
                         k, sout, ready, done, bit_tick);
            end
            tick();
        end
    endtask

    // d=1011: start 0, data 1,1,0,1, stop 1 -> bit p of the frame is exp_seq[p]
    task automatic test_frame();
        logic [5:0] exp_seq;
        logic       exp_t;
        exp_seq = 6'b110110;
        load = 1'b1;
        d    = 4'b1011;
        tick();
        load = 1'b0;
        for (int k = 0; k < 24; k++) begin
            exp_t = ((k % 4) == 3);
            tests++;
            if (sout !== exp_seq[k/4] || ready !== 1'b0 || done !== 1'b0 || bit_tick !== exp_t) begin
                fails++;
                $display("FAIL frame_1011 cyc=%0d got sout=%b ready=%b done=%b bit_tick=%b, required %b 0 0 %b",
                         k, sout, ready, done, bit_tick, exp_seq[k/4], exp_t);
            end
            tick();
        end
        tests++;
        if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b1 || bit_tick !== 1'b0) begin
            fails++;
            $display("FAIL frame_done got sout=%b ready=%b done=%b bit_tick=%b, required 1 1 1 0",
                     sout, ready, done, bit_tick);
        end
        tick();
        tests++;
        if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL frame_after_done got sout=%b ready=%b done=%b, required 1 1 0",
                     sout, ready, done);
        end
    endtask

    task automatic test_ignore_load();
        logic [5:0] exp_seq;
        exp_seq = 6'b110110;
        load = 1'b1;
        d    = 4'b1011;
        tick();
        load = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tests++;
            if (sout !== exp_seq[k/4] || ready !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL ignore_load cyc=%0d got sout=%b ready=%b done=%b, required %b 0 0",
                         k, sout, ready, done, exp_seq[k/4]);
            end
            if (k == 9) begin
                load = 1'b1;
                d    = 4'b0000;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        tests++;
        if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL ignore_load_done got sout=%b ready=%b done=%b, required 1 1 1",
                     sout, ready, done);
        end
        tick();
    endtask

    // d=0101: start 0, data 1,0,1,0, stop 1
    task automatic test_back_to_back();
        logic [5:0] exp_seq;
        exp_seq = 6'b101010;
        load = 1'b1;
        d    = 4'b0101;
        tick();
        for (int k = 0; k < 24; k++) begin
            tests++;
            if (sout !== exp_seq[k/4] || ready !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL b2b_frame1 cyc=%0d got sout=%b ready=%b done=%b, required %b 0 0",
                         k, sout, ready, done, exp_seq[k/4]);
            end
            tick();
        end
        tests++;
        if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_gap got sout=%b ready=%b done=%b, required 1 1 1",
                     sout, ready, done);
        end
        tick();
        for (int k = 0; k < 24; k++) begin
            tests++;
            if (sout !== exp_seq[k/4] || ready !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL b2b_frame2 cyc=%0d got sout=%b ready=%b done=%b, required %b 0 0",
                         k, sout, ready, done, exp_seq[k/4]);
            end
            if (k == 20) load = 1'b0;
            tick();
        end
        tests++;
        if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done2 got sout=%b ready=%b done=%b, required 1 1 1",
                     sout, ready, done);
        end
        tick();
        tests++;
        if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle got sout=%b ready=%b done=%b, required 1 1 0",
                     sout, ready, done);
        end
    endtask

    task automatic test_clr_mid();
        logic [5:0] exp_seq;
        exp_seq = 6'b110110;
        load = 1'b1;
        d    = 4'b1011;
        tick();
        load = 1'b0;
        // cycles 12..15 carry data bit index 2; abort at cycle 13
        for (int k = 0; k < 14; k++) begin
            tests++;
            if (sout !== exp_seq[k/4]) begin
                fails++;
                $display("FAIL clr_mid_pre cyc=%0d got sout=%b, required %b", k, sout, exp_seq[k/4]);
            end
            if (k == 13) clr = 1'b1;
            tick();
        end
        clr = 1'b0;
        tests++;
        if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b0 || bit_tick !== 1'b0) begin
            fails++;
            $display("FAIL clr_mid_abort got sout=%b ready=%b done=%b bit_tick=%b, required 1 1 0 0",
                     sout, ready, done, bit_tick);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL clr_mid_idle cyc=%0d got sout=%b ready=%b done=%b, required 1 1 0",
                         k, sout, ready, done);
            end
        end
        // fresh frame d=0110: start 0, data 0,1,1,0, stop 1
        exp_seq = 6'b101100;
        load = 1'b1;
        d    = 4'b0110;
        tick();
        load = 1'b0;
        for (int k = 0; k < 24; k++) begin
            tests++;
            if (sout !== exp_seq[k/4] || ready !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL clr_mid_fresh cyc=%0d got sout=%b ready=%b done=%b, required %b 0 0",
                         k, sout, ready, done, exp_seq[k/4]);
            end
            tick();
        end
        tests++;
        if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL clr_mid_fresh_done got sout=%b ready=%b done=%b, required 1 1 1",
                     sout, ready, done);
        end
        tick();
    endtask

    task automatic test_clr_load();
        clr  = 1'b1;
        load = 1'b1;
        d    = 4'b0000;
        tick();
        clr  = 1'b0;
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (sout !== 1'b1 || ready !== 1'b1 || done !== 1'b0 || bit_tick !== 1'b0) begin
                fails++;
                $display("FAIL clr_load cyc=%0d got sout=%b ready=%b done=%b bit_tick=%b, required 1 1 0 0",
                         k, sout, ready, done, bit_tick);
            end
            tick();
        end
    endtask

    initial begin
        clr  = 1'b0;
        load = 1'b0;
        d    = 4'b0000;
        test_reset();
        test_frame();
        test_ignore_load();
        test_back_to_back();
        test_clr_mid();
        test_clr_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_serializer.md
REG_SERIALIZER -- requirements
Module: reg_serializer

Interface
REQ-001 Parameter CLK_DIV, default 50000000: clk cycles per serial bit period (1 bit/s at 50 MHz); legal range 2..2^26-1.
REQ-002 Parameter DATA_W, default 4: width of parallel data word.
REQ-003 clk  input  1  system clock; all state SHALL update on its rising edge only (single clock domain).
REQ-004 clr  input  1  reset, synchronous and active-high.
REQ-005 load  input  1  transmit request; sampled on rising clk edge.
REQ-006 d  input  DATA_W  parallel word to transmit; sampled when load is accepted.
REQ-007 ready  output  1  high when idle and able to accept load.
REQ-008 sout  output  1  serial line; idle level 1.
REQ-009 bit_tick  output  1  one-cycle strobe at each bit-period boundary while transmitting.
REQ-010 done  output  1  one-cycle pulse on frame completion.

Function
REQ-011 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, stop bit (1); total DATA_W+2 bit periods.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: sout=1, ready=1; load=1 SHALL capture d into the shift register, clear the divider and bit index, and go to START.
REQ-014 Latency: sout SHALL be 0 on the first cycle after the edge that accepted load.
REQ-015 Each bit SHALL be held on sout for exactly CLK_DIV cycles; the divider counts 0..CLK_DIV-1, then wraps to 0.
REQ-016 bit_tick SHALL be 1 on the cycle the divider equals CLK_DIV-1 in START, DATA or STOP; 0 otherwise, including in IDLE.
REQ-017 START -> DATA on bit_tick; sout = shift register bit 0.
REQ-018 DATA: on bit_tick, the shift register SHALL shift right by one and the bit index increment; after the bit with index DATA_W-1, go to STOP.
REQ-019 STOP: sout=1; on bit_tick go to IDLE.
REQ-020 done SHALL be 1 on exactly the first IDLE cycle after STOP, and 0 otherwise.
REQ-021 ready SHALL be 0 in START, DATA and STOP; load in those states SHALL be ignored, and d changes SHALL NOT affect the frame in flight.
REQ-022 Back-to-back: load=1 in the done cycle SHALL be accepted, so sout is 1 for exactly one cycle between frames.
REQ-023 sout, ready, bit_tick and done SHALL be registered outputs (no combinational path from load or d).
REQ-024 Divider SHALL be 26 bits wide; the bit index SHALL be wide enough to count to DATA_W-1.

Reset
REQ-025 clr=1 on a rising edge SHALL force IDLE, with sout=1, ready=1, bit_tick=0, done=0, divider=0, bit index=0 and the shift register=0.
REQ-026 clr SHALL take priority over load in the same cycle; that load SHALL be discarded.
REQ-027 clr mid-frame SHALL abort the frame without asserting done; sout=1 from the next cycle.

Verification (CLK_DIV=4, DATA_W=4)
REQ-028 clr 2 cycles, then idle -> sout=1, ready=1, done=0 and bit_tick=0 throughout.
REQ-029 load=1 with d=4'b1011 for one cycle -> sout sequence 0,1,1,0,1,1, each value held 4 cycles; 5 bit_tick pulses in the frame (one per boundary), a 6th on the last stop cycle; done one cycle later; ready low for exactly 24 cycles.
REQ-030 load pulsed again mid-frame with d=4'b0000 -> ignored; the frame still shows data 1,1,0,1.
REQ-031 load held high continuously with d=4'b0101 -> consecutive frames separated by a single sout=1 idle cycle (the done cycle).
REQ-032 clr asserted during the DATA bit with index 2 -> sout=1 and ready=1 next cycle, with no done pulse; the next load transmits a complete fresh frame.
REQ-033 clr and load both high in IDLE -> remains IDLE, with sout=1 and no frame.
